// File: rtl/toy_bus_req_arb2_if.sv
// One toy_bus request/ack channel: single-beat requests out, acks back.
// master drives requests and accepts acks; slave accepts requests and returns acks.
interface toy_bus_req_arb2_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int SB_W   = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              req_vld;
    logic              req_rdy;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [STRB_W-1:0] req_strb;
    logic              req_opcode;
    logic [SB_W-1:0]   req_sideband;
    logic              ack_vld;
    logic              ack_rdy;
    logic [DATA_W-1:0] ack_data;
    logic [SB_W-1:0]   ack_sideband;

    modport master (
        output req_vld, req_addr, req_data, req_strb, req_opcode, req_sideband, ack_rdy,
        input  req_rdy, ack_vld, ack_data, ack_sideband
    );

    modport slave (
        input  req_vld, req_addr, req_data, req_strb, req_opcode, req_sideband, ack_rdy,
        output req_rdy, ack_vld, ack_data, ack_sideband
    );
endinterface

// File: rtl/toy_bus_req_arb2.sv
// Two-way round-robin arbiter onto one toy_bus core-slave request channel.
// Acks return to requesters in issue order through a 1-bit order FIFO.
module toy_bus_req_arb2 #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int SB_W      = 32,
    parameter int OST_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    toy_bus_req_arb2_if.slave  in0,
    toy_bus_req_arb2_if.slave  in1,
    toy_bus_req_arb2_if.master out
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(OST_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OST_DEPTH);

    logic              r_vld_p1;
    logic [ADDR_W-1:0] r_addr_p1;
    logic [DATA_W-1:0] r_data_p1;
    logic [STRB_W-1:0] r_strb_p1;
    logic              r_opcode_p1;
    logic [SB_W-1:0]   r_sideband_p1;
    logic              r_rr_ptr;
    logic [OST_DEPTH-1:0] r_fifo;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_load;
    logic              w_can_accept;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_push;
    logic              w_pop;
    logic              w_head;
    logic              w_ack_rdy;
    logic [ADDR_W-1:0] w_addr_p0;
    logic [DATA_W-1:0] w_data_p0;
    logic [STRB_W-1:0] w_strb_p0;
    logic              w_opcode_p0;
    logic [SB_W-1:0]   w_sideband_p0;

    // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
    assign w_full       = (r_count == DEPTH_C);
    assign w_empty      = (r_count == '0);
    assign w_load       = ~r_vld_p1 | out.req_rdy;
    assign w_can_accept = w_load & ~w_full;

    assign w_grant0 = in0.req_vld & (~in1.req_vld | ~r_rr_ptr);
    assign w_grant1 = in1.req_vld & (~in0.req_vld | r_rr_ptr);
    assign w_push   = w_can_accept & (w_grant0 | w_grant1);

    assign in0.req_rdy = w_can_accept & w_grant0;
    assign in1.req_rdy = w_can_accept & w_grant1;

    always_comb begin
        w_addr_p0     = in0.req_addr;
        w_data_p0     = in0.req_data;
        w_strb_p0     = in0.req_strb;
        w_opcode_p0   = in0.req_opcode;
        w_sideband_p0 = in0.req_sideband;
        if (w_grant1) begin
            w_addr_p0     = in1.req_addr;
            w_data_p0     = in1.req_data;
            w_strb_p0     = in1.req_strb;
            w_opcode_p0   = in1.req_opcode;
            w_sideband_p0 = in1.req_sideband;
        end
    end

    // Stage p0 -> p1: arbitrated request into the output buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_rr_ptr <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_load) r_vld_p1 <= w_push;
            if (w_push) begin
                r_rr_ptr <= ~w_grant1;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
            else if (~w_push & w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_p1        <= w_addr_p0;
            r_data_p1        <= w_data_p0;
            r_strb_p1        <= w_strb_p0;
            r_opcode_p1      <= w_opcode_p0;
            r_sideband_p1    <= w_sideband_p0;
            r_fifo[r_wr_ptr] <= w_grant1;
        end
    end

    assign out.req_vld      = r_vld_p1;
    assign out.req_addr     = r_addr_p1;
    assign out.req_data     = r_data_p1;
    assign out.req_strb     = r_strb_p1;
    assign out.req_opcode   = r_opcode_p1;
    assign out.req_sideband = r_sideband_p1;

    // Acks are steered to the FIFO head; with an empty FIFO they are held off entirely.
    assign w_head    = r_fifo[r_rd_ptr];
    assign w_ack_rdy = ~w_empty & (w_head ? in1.ack_rdy : in0.ack_rdy);
    assign w_pop     = out.ack_vld & w_ack_rdy;
    assign out.ack_rdy = w_ack_rdy;

    assign in0.ack_vld      = out.ack_vld & ~w_empty & ~w_head;
    assign in1.ack_vld      = out.ack_vld & ~w_empty & w_head;
    assign in0.ack_data     = out.ack_data;
    assign in1.ack_data     = out.ack_data;
    assign in0.ack_sideband = out.ack_sideband;
    assign in1.ack_sideband = out.ack_sideband;
endmodule

// File: tb/tb_toy_bus_req_arb2.sv
// Directed bench for toy_bus_req_arb2: arbitration, backpressure, ack ordering,
// outstanding limit and mid-traffic reset, plus an output-request stability monitor.
module tb_toy_bus_req_arb2;
    logic clk = 1'b0;
    logic rst;
    int   ntests = 0;
    int   nfail  = 0;

    logic         p_hold = 1'b0;
    logic [31:0]  p_addr;
    logic [255:0] p_data;

    toy_bus_req_arb2_if #(.ADDR_W(32), .DATA_W(256), .SB_W(32)) in0_if ();
    toy_bus_req_arb2_if #(.ADDR_W(32), .DATA_W(256), .SB_W(32)) in1_if ();
    toy_bus_req_arb2_if #(.ADDR_W(32), .DATA_W(256), .SB_W(32)) out_if ();

    toy_bus_req_arb2 #(.ADDR_W(32), .DATA_W(256), .SB_W(32), .OST_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .in0 (in0_if),
        .in1 (in1_if),
        .out (out_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output request must stay valid and stable until handshaken; at most one req_rdy.
    always @(negedge clk) begin
        if (!rst) begin
            if (p_hold) begin
                ntests++;
                assert (out_if.req_vld === 1'b1 && out_if.req_addr === p_addr &&
                        out_if.req_data === p_data) else begin
                    nfail++;
                    $error("FAIL out_req_stable: observed vld=%0b addr=%0h expected vld=1 addr=%0h",
                           out_if.req_vld, out_if.req_addr, p_addr);
                end
            end
            ntests++;
            assert (!(in0_if.req_rdy === 1'b1 && in1_if.req_rdy === 1'b1)) else begin
                nfail++;
                $error("FAIL rdy_onehot: observed both rdy high expected at most one");
            end
        end
        p_hold <= !rst && out_if.req_vld === 1'b1 && out_if.req_rdy === 1'b0;
        p_addr <= out_if.req_addr;
        p_data <= out_if.req_data;
    end

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0000;

    initial begin
        rst = 1'b1;
        in0_if.req_vld = 0; in0_if.req_addr = '0; in0_if.req_data = '0; in0_if.req_strb = '0;
        in0_if.req_opcode = 0; in0_if.req_sideband = '0; in0_if.ack_rdy = 0;
        in1_if.req_vld = 0; in1_if.req_addr = '0; in1_if.req_data = '0; in1_if.req_strb = '0;
        in1_if.req_opcode = 0; in1_if.req_sideband = '0; in1_if.ack_rdy = 0;
        out_if.req_rdy = 1; out_if.ack_vld = 0; out_if.ack_data = '0; out_if.ack_sideband = '0;
        tick();
        tick();
        chk("reset_out_vld", out_if.req_vld, 1'b0);
        chk("reset_ack_rdy", out_if.ack_rdy, 1'b0);
        chk("reset_count", dut.r_count, 0);
        rst = 1'b0;

        // Contention: both held valid, grants alternate starting with in0.
        in0_if.req_vld = 1; in0_if.req_addr = A0;
        in1_if.req_vld = 1; in1_if.req_addr = A1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_rdy0", in0_if.req_rdy, (i % 2) == 0);
            chk("cont_rdy1", in1_if.req_rdy, (i % 2) == 1);
            tick();
            chk("cont_out_vld", out_if.req_vld, 1'b1);
            chk("cont_out_addr", out_if.req_addr, ((i % 2) == 0) ? A0 : A1);
        end
        in0_if.req_vld = 0; in1_if.req_vld = 0;
        chk("cont_count", dut.r_count, 4);
        out_if.ack_vld = 1; in0_if.ack_rdy = 1; in1_if.ack_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ack0", in0_if.ack_vld, (i % 2) == 0);
            chk("cont_ack1", in1_if.ack_vld, (i % 2) == 1);
            tick();
        end
        out_if.ack_vld = 0;
        chk("cont_drained", dut.r_count, 0);
        chk("cont_out_idle", out_if.req_vld, 1'b0);

        // Single read on in0.
        in0_if.req_vld = 1; in0_if.req_addr = 32'h8000_0000; in0_if.req_opcode = 0;
        in0_if.req_sideband = 32'h11;
        #1;
        chk("rd_rdy0", in0_if.req_rdy, 1'b1);
        chk("rd_out_vld_pre", out_if.req_vld, 1'b0);
        tick();
        in0_if.req_vld = 0;
        chk("rd_out_vld", out_if.req_vld, 1'b1);
        chk("rd_out_addr", out_if.req_addr, 32'h8000_0000);
        chk("rd_out_op", out_if.req_opcode, 1'b0);
        chk("rd_out_sb", out_if.req_sideband, 32'h11);
        chk("rd_count1", dut.r_count, 1);
        tick();
        chk("rd_out_drained", out_if.req_vld, 1'b0);
        out_if.ack_vld = 1; out_if.ack_data = {32{8'hA5}}; out_if.ack_sideband = 32'h22;
        #1;
        chk("rd_ack0", in0_if.ack_vld, 1'b1);
        chk("rd_ack1", in1_if.ack_vld, 1'b0);
        chk("rd_ack_data", in0_if.ack_data, {32{8'hA5}});
        chk("rd_ack_sb", in0_if.ack_sideband, 32'h22);
        chk("rd_out_ack_rdy", out_if.ack_rdy, 1'b1);
        tick();
        out_if.ack_vld = 0;
        chk("rd_count0", dut.r_count, 0);

        // Backpressure: rr now favours in1; request parks in obuf.
        out_if.req_rdy = 0;
        in1_if.req_vld = 1; in1_if.req_addr = 32'h3000_0000; in1_if.req_data = {8{32'hDEAD_BEEF}};
        in1_if.req_strb = 32'hFFFF_0000; in1_if.req_opcode = 1; in1_if.req_sideband = 32'h33;
        in0_if.req_vld = 1; in0_if.req_addr = 32'h4000_0000; in0_if.req_opcode = 0;
        #1;
        chk("bp_rdy1", in1_if.req_rdy, 1'b1);
        chk("bp_rdy0", in0_if.req_rdy, 1'b0);
        tick();
        in1_if.req_vld = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_vld", out_if.req_vld, 1'b1);
            chk("bp_hold_addr", out_if.req_addr, 32'h3000_0000);
            chk("bp_hold_data", out_if.req_data, {8{32'hDEAD_BEEF}});
            chk("bp_hold_strb", out_if.req_strb, 32'hFFFF_0000);
            chk("bp_hold_op", out_if.req_opcode, 1'b1);
            chk("bp_rdy0_low", in0_if.req_rdy, 1'b0);
            chk("bp_rdy1_low", in1_if.req_rdy, 1'b0);
            tick();
        end
        out_if.req_rdy = 1;
        #1;
        chk("bp_release_rdy0", in0_if.req_rdy, 1'b1);
        chk("bp_release_addr", out_if.req_addr, 32'h3000_0000);
        tick();
        in0_if.req_vld = 0;
        chk("bp_next_addr", out_if.req_addr, 32'h4000_0000);
        chk("bp_next_op", out_if.req_opcode, 1'b0);
        tick();
        chk("bp_idle", out_if.req_vld, 1'b0);

        // Third request (in1) -> order in1, in0, in1.
        in1_if.req_vld = 1; in1_if.req_addr = 32'h5000_0000; in1_if.req_opcode = 0;
        #1;
        chk("ord_rdy1", in1_if.req_rdy, 1'b1);
        tick();
        in1_if.req_vld = 0;
        tick();
        chk("ord_count3", dut.r_count, 3);

        // Ack stall: head is in1 which is not ready.
        out_if.ack_vld = 1; out_if.ack_data = {32{8'h5A}};
        in0_if.ack_rdy = 1; in1_if.ack_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_out_ack_rdy", out_if.ack_rdy, 1'b0);
            chk("stall_ack0", in0_if.ack_vld, 1'b0);
            chk("stall_ack1", in1_if.ack_vld, 1'b1);
            tick();
        end
        chk("stall_count", dut.r_count, 3);
        in1_if.ack_rdy = 1;
        #1;
        chk("stall_release_rdy", out_if.ack_rdy, 1'b1);
        tick();
        chk("ord_ack0", in0_if.ack_vld, 1'b1);
        chk("ord_ack0_n1", in1_if.ack_vld, 1'b0);
        tick();
        chk("ord_ack1", in1_if.ack_vld, 1'b1);
        chk("ord_ack1_n0", in0_if.ack_vld, 1'b0);
        tick();
        chk("ord_count0", dut.r_count, 0);

        // Spurious ack with empty FIFO is held, then delivered once a request is issued.
        out_if.ack_data = 256'h77;
        #1;
        chk("spur_rdy", out_if.ack_rdy, 1'b0);
        chk("spur_ack0", in0_if.ack_vld, 1'b0);
        chk("spur_ack1", in1_if.ack_vld, 1'b0);
        tick();
        chk("spur_held_rdy", out_if.ack_rdy, 1'b0);
        in0_if.req_vld = 1; in0_if.req_addr = 32'h0000_0040;
        #1;
        chk("spur_req_rdy0", in0_if.req_rdy, 1'b1);
        tick();
        in0_if.req_vld = 0;
        #1;
        chk("spur_ack0_late", in0_if.ack_vld, 1'b1);
        chk("spur_ack_data", in0_if.ack_data, 256'h77);
        chk("spur_out_rdy", out_if.ack_rdy, 1'b1);
        tick();
        out_if.ack_vld = 0;
        chk("spur_count0", dut.r_count, 0);

        // Outstanding limit: 8 accepts with no acks.
        in0_if.req_vld = 1; in0_if.req_addr = 32'h6000_0000;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("ost_rdy0", in0_if.req_rdy, 1'b1);
            tick();
        end
        #1;
        chk("ost_full_rdy0", in0_if.req_rdy, 1'b0);
        chk("ost_count8", dut.r_count, 8);
        tick();
        chk("ost_out_idle", out_if.req_vld, 1'b0);
        chk("ost_still_full", in0_if.req_rdy, 1'b0);
        out_if.ack_vld = 1;
        #1;
        chk("ost_pop_rdy", out_if.ack_rdy, 1'b1);
        chk("ost_pop_no_push", in0_if.req_rdy, 1'b0);
        tick();
        out_if.ack_vld = 0;
        #1;
        chk("ost_count7", dut.r_count, 7);
        chk("ost_one_more", in0_if.req_rdy, 1'b1);
        tick();
        #1;
        chk("ost_full_again", in0_if.req_rdy, 1'b0);
        chk("ost_count8b", dut.r_count, 8);
        in0_if.req_vld = 0;
        out_if.ack_vld = 1;
        for (int i = 0; i < 8; i++) tick();
        out_if.ack_vld = 0;
        chk("ost_drained", dut.r_count, 0);

        // Reset with 3 outstanding; last accept is in0 so rr points at in1 before reset.
        in1_if.req_vld = 1; in1_if.req_addr = 32'h7000_0000;
        #1;
        chk("rst_pre_rdy1", in1_if.req_rdy, 1'b1);
        tick();
        tick();
        in1_if.req_vld = 0;
        in0_if.req_vld = 1; in0_if.req_addr = 32'h7100_0000;
        tick();
        in0_if.req_vld = 0;
        out_if.req_rdy = 0;
        #1;
        chk("rst_pre_vld", out_if.req_vld, 1'b1);
        chk("rst_pre_count", dut.r_count, 3);
        rst = 1'b1;
        #1;
        chk("rst_async_vld", out_if.req_vld, 1'b0);
        chk("rst_async_count", dut.r_count, 0);
        tick();
        tick();
        rst = 1'b0;
        out_if.req_rdy = 1;
        in0_if.req_vld = 1; in0_if.req_addr = 32'h0A00_0000;
        in1_if.req_vld = 1; in1_if.req_addr = 32'h0B00_0000;
        #1;
        chk("rst_first_rdy0", in0_if.req_rdy, 1'b1);
        chk("rst_first_rdy1", in1_if.req_rdy, 1'b0);
        chk("rst_ack_rdy", out_if.ack_rdy, 1'b0);
        tick();
        in0_if.req_vld = 0; in1_if.req_vld = 0;
        chk("rst_first_addr", out_if.req_addr, 32'h0A00_0000);
        chk("rst_first_count", dut.r_count, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/toy_bus_req_arb2.md
Name: toy_bus_req_arb2

Overview:
- Shares one toy-bus core-slave request channel between two requesters: in0 (LSU) and in1 (fetch).
- Single-beat requests. Round-robin arbitration, one registered output stage, and in-order ack routing through an outstanding-order FIFO.
- Sits between the core requesters and the toy_bus core-slave node. Its out_* ports connect directly to that node's in0_req_* and in0_ack_* ports.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 256, request/ack data width; strb width is DATA_W/8
- SB_W, 32, sideband width
- OST_DEPTH, 8, maximum outstanding requests awaiting ack; power of 2, at least 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- inN_req_vld  in  1  request valid, N = 0, 1
- inN_req_rdy  out  1  request accepted when vld & rdy
- inN_req_addr  in  ADDR_W  request address
- inN_req_data  in  DATA_W  write data
- inN_req_strb  in  DATA_W/8  byte strobes
- inN_req_opcode  in  1  0 = read, 1 = write
- inN_req_sideband  in  SB_W  opaque, passed through
- inN_ack_vld  out  1  ack valid
- inN_ack_rdy  in  1  ack ready
- inN_ack_data  out  DATA_W  ack data
- inN_ack_sideband  out  SB_W  ack sideband
- out_req_vld/rdy/addr/data/strb/opcode/sideband  out/in/out/out/out/out/out  as inN_req_*  arbitrated request
- out_ack_vld  in  1  ack valid from node
- out_ack_rdy  out  1  ack ready to node
- out_ack_data  in  DATA_W  ack data from node
- out_ack_sideband  in  SB_W  ack sideband from node

Behaviour:
- Reset values (async assert, sync release): out_req_vld = 0, rr_ptr = 0 (in0 has priority first), FIFO empty (wr_ptr = rd_ptr = 0, count = 0). Output payload registers are don't-care, but the bench must never sample them while vld = 0.
- Output stage: one-entry register (obuf).
  - obuf loads when it is empty, or when it drains this cycle (out_req_vld & out_req_rdy).
  - Latency: inN accept to out_req_vld is exactly 1 cycle.
  - Full throughput: one request per cycle when out_req_rdy is held at 1.
- can_accept = (obuf empty | out_req_rdy) & (ost_count < OST_DEPTH).
- Arbitration:
  - Both valid: the port indicated by rr_ptr wins.
  - One valid: that port wins.
  - The grant is combinational. inN_req_rdy = can_accept & grantN; at most one rdy is high per cycle.
  - On an accepted grant, rr_ptr = ~winner. rr_ptr is unchanged when nothing is accepted.
- Order FIFO:
  - Each accepted request pushes its winner index (1 bit).
  - Pushed at the accept, not at out handshake, so the obuf entry counts as outstanding.
- Ack routing, combinational:
  - head = FIFO head index.
  - in<head>_ack_vld = out_ack_vld & ~empty; the other port's ack_vld = 0.
  - out_ack_rdy = in<head>_ack_rdy & ~empty.
  - Data and sideband are broadcast to both ports.
  - An ack handshake pops the FIFO.
- FIFO empty: out_ack_rdy = 0 and no inN_ack_vld. A spurious out_ack_vld is held off and never lost or routed.
- FIFO full (count = OST_DEPTH): both req_rdy = 0. A pop in the same cycle does not enable a push; the full flag is registered.
- Simultaneous push and pop: count unchanged, pointers both advance, wrapping modulo OST_DEPTH.
- Reset mid-operation: obuf and FIFO are cleared immediately. In-flight acks are discarded by the environment.
- vld, once asserted on any interface, is never dropped without a handshake, and payload stays stable. Protocol assertions in the bench enforce this.

Test Plan:
- Single read: in0 read addr 0x8000_0000. Then out_req_vld rises 1 cycle after accept. out_ack with data 0xA5.. then goes only to in0_ack, and ost_count returns to 0.
- Contention: in0 and in1 held valid for 4 cycles with out_req_rdy = 1. Grants are in0, in1, in0, in1, and out addrs alternate between the two ports' addresses.
- Backpressure: out_req_rdy = 0 for 5 cycles. One request sits in obuf and both req_rdy = 0. When rdy = 1, the request drains with payload unchanged.
- Outstanding limit: OST_DEPTH = 8, no acks, out_req_rdy = 1. Exactly 8 accepts, then req_rdy = 0. One ack then allows exactly one more accept on the following cycle.
- Ack ordering/stall: order in1, in0, in1, with in1_ack_rdy = 0 while in0_ack_rdy = 1. out_ack_rdy stays 0 and in0 gets no ack until in1 accepts its first ack.
- Reset mid-traffic: assert rst with 3 outstanding. out_req_vld drops asynchronously. After release, the FIFO is empty and the first grant goes to in0.
